// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams and FIFO write-port signals of fifo_wr_arbiter.
// slave = arbiter view, master = the side driving requesters and FIFO status.
interface fifo_wr_arbiter_if #(
   parameter int NUM   = 4,
   parameter int DSIZE = 8
);
   localparam int GW = $clog2(NUM);

   logic [NUM*DSIZE-1:0] req_data;
   logic [NUM-1:0]       req_valid;
   logic [NUM-1:0]       req_last;
   logic [NUM-1:0]       req_ready;
   logic [DSIZE-1:0]     fifo_wdata;
   logic                 fifo_wr_en;
   logic                 fifo_full;
   logic [GW-1:0]        grant_id;
   logic                 busy;

   modport slave (
      input  req_data, req_valid, req_last, fifo_full,
      output req_ready, fifo_wdata, fifo_wr_en, grant_id, busy
   );

   modport master (
      output req_data, req_valid, req_last, fifo_full,
      input  req_ready, fifo_wdata, fifo_wr_en, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among NUM requesters.
// Optional per-grant word limit: define FIFO_ARB_BURST_LIMIT_EN (uses MAX_BURST).
module fifo_wr_arbiter #(
   parameter int NUM       = 4,
   parameter int DSIZE     = 8,
   parameter int MAX_BURST = 16
) (
   input  logic              clock,
   input  logic              rst_n,
   fifo_wr_arbiter_if.slave  bus
);
   localparam int GW = $clog2(NUM);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [GW-1:0]      r_rr_ptr;
   logic [GW-1:0]      r_grant_id;
   logic [GW-1:0]      w_pick;
   logic               w_found;
   logic [GW-1:0]      w_next_ptr;
   logic [NUM-1:0]     w_ready;
   logic [DSIZE-1:0]   w_wdata;
   logic               w_xfer;
   logic               w_release;
   logic               w_burst_hit;
   logic               w_gnt_valid;
   logic               w_gnt_last;

   // A burst limit below one word would never let a grant make progress.
   if (MAX_BURST < 1) begin : g_bad_max_burst
   end

   // First valid requester at or after rr_ptr, wrapping modulo NUM.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      for (int unsigned k = 0; k < NUM; k++) begin
         idx = (int'(r_rr_ptr) + k) % NUM;
         if (!w_found && bus.req_valid[idx]) begin
            w_found = 1'b1;
            w_pick  = GW'(idx);
         end
      end
   end

   always_comb begin
      w_wdata     = bus.req_data[DSIZE-1:0];
      w_gnt_valid = 1'b0;
      w_gnt_last  = 1'b0;
      for (int unsigned i = 0; i < NUM; i++) begin
         if (r_grant_id == GW'(i)) begin
            w_wdata     = bus.req_data[i*DSIZE +: DSIZE];
            w_gnt_valid = bus.req_valid[i];
            w_gnt_last  = bus.req_last[i];
         end
      end
   end

   assign w_next_ptr = (r_grant_id == GW'(NUM - 1)) ? '0 : r_grant_id + GW'(1);

`ifdef FIFO_ARB_BURST_LIMIT_EN
   localparam int BW = $clog2(MAX_BURST + 1);

   logic [BW-1:0] r_burst_cnt;

   assign w_burst_hit = (r_burst_cnt == BW'(MAX_BURST - 1));

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_burst_cnt <= '0;
      end else if (r_state == IDLE) begin
         r_burst_cnt <= '0;
      end else if (w_xfer) begin
         r_burst_cnt <= r_burst_cnt + BW'(1);
      end
   end
`else
   assign w_burst_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_found) begin
            r_grant_id <= w_pick;
         end
         if (w_release) begin
            r_rr_ptr <= w_next_ptr;
         end
      end
   end

   // Ready and wr_en both gate on !full, so a full FIFO simply stalls the grant.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = '0;
      w_xfer      = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            w_ready[r_grant_id] = !bus.fifo_full;
            w_xfer              = w_gnt_valid & !bus.fifo_full;
            if (w_xfer && (w_gnt_last || w_burst_hit)) begin
               w_release   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.req_ready  = w_ready;
   assign bus.fifo_wdata = w_wdata;
   assign bus.fifo_wr_en = w_xfer;
   assign bus.grant_id   = r_grant_id;
   assign bus.busy       = (r_state == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-lane packet queues feed the requesters,
// every FIFO write is logged as {grant_id, data} and compared with hand-written values.
module tb_fifo_wr_arbiter;
   logic clock;
   logic rst_n;

   fifo_wr_arbiter_if #(.NUM(4), .DSIZE(8)) bus ();

   fifo_wr_arbiter #(.NUM(4), .DSIZE(8), .MAX_BURST(4)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [8:0]  lane_q [4][$];
   logic [3:0]  hold;
   logic [9:0]  wr_log [$];
   logic [9:0]  exp5 [$];
   logic [11:0] wr_hist;
   int          n_checks;
   int          n_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_log(input string tag, input int idx, input logic [9:0] exp);
      logic [9:0] obs;
      obs = (idx < wr_log.size()) ? wr_log[idx] : 10'h3FF;
      chk(tag, {22'd0, obs}, {22'd0, exp});
   endtask

   task automatic drive();
      logic [31:0] d;
      logic [3:0]  v;
      logic [3:0]  l;
      for (int i = 0; i < 4; i++) begin
         if (lane_q[i].size() > 0 && !hold[i]) begin
            v[i]         = 1'b1;
            l[i]         = lane_q[i][0][8];
            d[i*8 +: 8]  = lane_q[i][0][7:0];
         end else begin
            v[i]         = 1'b0;
            l[i]         = 1'b0;
            d[i*8 +: 8]  = 8'hE0 | 8'(i);
         end
      end
      bus.req_data  = d;
      bus.req_valid = v;
      bus.req_last  = l;
   endtask

   // Sample the handshake before the edge, pop accepted words after it.
   task automatic cycle();
      logic [3:0] fire;
      fire = bus.req_valid & bus.req_ready;
      if (bus.fifo_wr_en) wr_log.push_back({bus.grant_id, bus.fifo_wdata});
      wr_hist = {wr_hist[10:0], bus.fifo_wr_en};
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (fire[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
      end
      drive();
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      hold          = '0;
      wr_hist       = '0;
      rst_n         = 1'b0;
      bus.fifo_full = 1'b0;
      drive();
      run(2);

      // Reset state
      chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("rst_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("rst_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
      chk("rst_gid",   {30'd0, bus.grant_id}, 32'd0);
      chk("rst_wdata", {24'd0, bus.fifo_wdata}, 32'hE0);
      rst_n = 1'b1;
      run(1);

      // All four lanes valid with 1-word packets: grants 0,1,2,3,0,1
      wr_log.delete();
      lane_q[0].push_back({1'b1, 8'h20}); lane_q[0].push_back({1'b1, 8'h30});
      lane_q[1].push_back({1'b1, 8'h21}); lane_q[1].push_back({1'b1, 8'h31});
      lane_q[2].push_back({1'b1, 8'h22});
      lane_q[3].push_back({1'b1, 8'h23});
      drive(); #1;
      wr_hist = '0;
      run(12);
      chk("rr_wr_pattern", {20'd0, wr_hist}, 32'h555);
      chk("rr_count", wr_log.size(), 32'd6);
      chk_log("rr_0", 0, {2'd0, 8'h20});
      chk_log("rr_1", 1, {2'd1, 8'h21});
      chk_log("rr_2", 2, {2'd2, 8'h22});
      chk_log("rr_3", 3, {2'd3, 8'h23});
      chk_log("rr_4", 4, {2'd0, 8'h30});
      chk_log("rr_5", 5, {2'd1, 8'h31});

      // Single requester, 3-word packet
      wr_log.delete();
      lane_q[1].push_back({1'b0, 8'h10});
      lane_q[1].push_back({1'b0, 8'h11});
      lane_q[1].push_back({1'b1, 8'h12});
      drive(); #1;
      chk("p1_idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("p1_idle_ready", {28'd0, bus.req_ready}, 32'd0);
      cycle();
      chk("p1_busy",  {31'd0, bus.busy}, 32'd1);
      chk("p1_gid",   {30'd0, bus.grant_id}, 32'd1);
      chk("p1_ready", {28'd0, bus.req_ready}, 32'h2);
      chk("p1_wdata", {24'd0, bus.fifo_wdata}, 32'h10);
      run(3);
      chk("p1_end_busy",  {31'd0, bus.busy}, 32'd0);
      chk("p1_end_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
      chk("p1_count", wr_log.size(), 32'd3);
      chk_log("p1_w0", 0, {2'd1, 8'h10});
      chk_log("p1_w1", 1, {2'd1, 8'h11});
      chk_log("p1_w2", 2, {2'd1, 8'h12});

      // fifo_full for 5 cycles in the middle of a req0 packet
      wr_log.delete();
      lane_q[0].push_back({1'b0, 8'h40});
      lane_q[0].push_back({1'b0, 8'h41});
      lane_q[0].push_back({1'b0, 8'h42});
      lane_q[0].push_back({1'b1, 8'h43});
      drive(); #1;
      run(2);
      bus.fifo_full = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("full_ready", {28'd0, bus.req_ready}, 32'd0);
         chk("full_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
         chk("full_busy",  {31'd0, bus.busy}, 32'd1);
         cycle();
      end
      bus.fifo_full = 1'b0;
      #1;
      chk("full_resume_wr_en", {31'd0, bus.fifo_wr_en}, 32'd1);
      chk("full_resume_wdata", {24'd0, bus.fifo_wdata}, 32'h41);
      run(4);
      chk("full_count", wr_log.size(), 32'd4);
      chk_log("full_w0", 0, {2'd0, 8'h40});
      chk_log("full_w1", 1, {2'd0, 8'h41});
      chk_log("full_w2", 2, {2'd0, 8'h42});
      chk_log("full_w3", 3, {2'd0, 8'h43});

      // Granted req0 drops valid for 3 cycles while req1 waits
      wr_log.delete();
      lane_q[0].push_back({1'b0, 8'h60});
      lane_q[0].push_back({1'b0, 8'h61});
      lane_q[0].push_back({1'b1, 8'h62});
      drive(); #1;
      run(2);
      hold[0] = 1'b1;
      lane_q[1].push_back({1'b1, 8'h70});
      drive(); #1;
      for (int i = 0; i < 3; i++) begin
         chk("gap_gid",   {30'd0, bus.grant_id}, 32'd0);
         chk("gap_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
         chk("gap_ready", {28'd0, bus.req_ready}, 32'h1);
         cycle();
      end
      hold[0] = 1'b0;
      drive(); #1;
      chk("gap_resume_wdata", {24'd0, bus.fifo_wdata}, 32'h61);
      run(7);
      chk("gap_count", wr_log.size(), 32'd4);
      chk_log("gap_w0", 0, {2'd0, 8'h60});
      chk_log("gap_w1", 1, {2'd0, 8'h61});
      chk_log("gap_w2", 2, {2'd0, 8'h62});
      chk_log("gap_w3", 3, {2'd1, 8'h70});

      // Reset during word 2 of a 6-word req2 packet
      for (int i = 0; i < 6; i++) lane_q[2].push_back({(i == 5), 8'h80 + 8'(i)});
      drive(); #1;
      run(2);
      rst_n = 1'b0;
      #1;
      cycle();
      chk("mrst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("mrst_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("mrst_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
      rst_n = 1'b1;
      lane_q[2].delete();
      lane_q[1].push_back({1'b1, 8'h90});
      lane_q[3].push_back({1'b1, 8'hB0});
      drive(); #1;
      wr_log.delete();
      cycle();
      chk("mrst_rearb_gid", {30'd0, bus.grant_id}, 32'd1);
      run(6);
      chk("mrst_count", wr_log.size(), 32'd2);
      chk_log("mrst_w0", 0, {2'd1, 8'h90});
      chk_log("mrst_w1", 1, {2'd3, 8'hB0});

      // 10-word req2 packet while req3 is valid
      wr_log.delete();
      for (int i = 0; i < 10; i++) lane_q[2].push_back({(i == 9), 8'hC0 + 8'(i)});
      lane_q[3].push_back({1'b1, 8'hD0});
`ifdef FIFO_ARB_BURST_LIMIT_EN
      for (int i = 0; i < 4; i++) exp5.push_back({2'd2, 8'hC0 + 8'(i)});
      exp5.push_back({2'd3, 8'hD0});
      for (int i = 4; i < 10; i++) exp5.push_back({2'd2, 8'hC0 + 8'(i)});
`else
      for (int i = 0; i < 10; i++) exp5.push_back({2'd2, 8'hC0 + 8'(i)});
      exp5.push_back({2'd3, 8'hD0});
`endif
      drive(); #1;
      run(26);
      chk("burst_count", wr_log.size(), 32'd11);
      for (int i = 0; i < 11; i++) chk_log("burst_word", i, exp5[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
